// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in, serial-out serializer. A WIDTH-bit word is taken over a
// valid/ready handshake and shifted out MSB-first, one bit per i_shift tick.
// Feeding o_sdata and the same i_shift tick into the serial-in left-shift
// register reassembles the word on the receive side.
//
// Parameters:
//   WIDTH       data word width in bits (2..64)
//   IDLE_LEVEL  level driven on o_sdata when no frame is in progress
//
// Ports:
//   i_clk     clock
//   i_rst_n   synchronous active-low reset
//   i_data    parallel word to transmit (sampled on the accept edge only)
//   i_valid   i_data valid
//   o_ready   word can be accepted this cycle (combinational)
//   i_shift   bit-advance tick (continuous or sparse)
//   o_sdata   serial data out
//   o_active  high while a frame bit is being driven
//   o_done    registered one-cycle pulse when a frame completes
//
// Optional feature macro: PISO_SERIALIZER_PARITY_EN
//   When defined, an even-parity bit (XOR of the word) follows the LSB and
//   the frame is WIDTH+1 bits long. When undefined no parity logic exists.
// -----------------------------------------------------------------------------
module piso_serializer #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_shift,
    output logic             o_sdata,
    output logic             o_active,
    output logic             o_done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

`ifdef PISO_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;
`else
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;
`endif

    state_t           state_r;
    logic [WIDTH-1:0] shreg_r;
    logic [CW-1:0]    cnt_r;
    logic             done_r;
`ifdef PISO_SERIALIZER_PARITY_EN
    logic             par_r;
`endif

    logic final_bit_s;
    logic ready_s;
    logic accept_s;
    logic sdata_s;
    logic active_s;

`ifdef PISO_SERIALIZER_PARITY_EN
    // Even parity of a word: XOR reduction of all its bits.
    function automatic logic even_parity(input logic [WIDTH-1:0] data);
        even_parity = ^data;
    endfunction
`endif

    // Identify the state that drives the last bit of a frame.
    always_comb begin
        final_bit_s = 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
        if (state_r == ST_PARITY) begin
            final_bit_s = 1'b1;
        end else begin
            final_bit_s = 1'b0;
        end
`else
        if ((state_r == ST_SHIFT) && (cnt_r == {CW{1'b0}})) begin
            final_bit_s = 1'b1;
        end else begin
            final_bit_s = 1'b0;
        end
`endif
    end

    // Ready when idle, or when the last bit retires this cycle so the next
    // word can follow without a gap; never ready while reset is asserted.
    always_comb begin
        ready_s = 1'b0;
        if (!i_rst_n) begin
            ready_s = 1'b0;
        end else if (state_r == ST_IDLE) begin
            ready_s = 1'b1;
        end else if (final_bit_s && i_shift) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
    end

    assign accept_s = i_valid && ready_s;

    // Frame state machine: load, shift on tick, complete and optional reload.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
            shreg_r <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            done_r  <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
            par_r   <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        shreg_r <= i_data;
                        cnt_r   <= CNT_LOAD;
                        state_r <= ST_SHIFT;
`ifdef PISO_SERIALIZER_PARITY_EN
                        par_r   <= even_parity(i_data);
`endif
                    end
                end
                ST_SHIFT: begin
                    if (i_shift) begin
                        if (cnt_r != {CW{1'b0}}) begin
                            shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
                            cnt_r   <= cnt_r - CW'(1);
                        end else begin
`ifdef PISO_SERIALIZER_PARITY_EN
                            // LSB retired: parity bit goes out next.
                            state_r <= ST_PARITY;
`else
                            done_r <= 1'b1;
                            if (accept_s) begin
                                shreg_r <= i_data;
                                cnt_r   <= CNT_LOAD;
                                state_r <= ST_SHIFT;
                            end else begin
                                state_r <= ST_IDLE;
                            end
`endif
                        end
                    end
                end
`ifdef PISO_SERIALIZER_PARITY_EN
                ST_PARITY: begin
                    if (i_shift) begin
                        done_r <= 1'b1;
                        if (accept_s) begin
                            shreg_r <= i_data;
                            cnt_r   <= CNT_LOAD;
                            par_r   <= even_parity(i_data);
                            state_r <= ST_SHIFT;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
`endif
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Serial output mux; forced to the idle level while reset is asserted.
    always_comb begin
        sdata_s  = IDLE_LEVEL;
        active_s = 1'b0;
        if (!i_rst_n) begin
            sdata_s  = IDLE_LEVEL;
            active_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    sdata_s  = IDLE_LEVEL;
                    active_s = 1'b0;
                end
                ST_SHIFT: begin
                    sdata_s  = shreg_r[WIDTH-1];
                    active_s = 1'b1;
                end
`ifdef PISO_SERIALIZER_PARITY_EN
                ST_PARITY: begin
                    sdata_s  = par_r;
                    active_s = 1'b1;
                end
`endif
                default: begin
                    sdata_s  = IDLE_LEVEL;
                    active_s = 1'b0;
                end
            endcase
        end
    end

    assign o_ready  = ready_s;
    assign o_sdata  = sdata_s;
    assign o_active = active_s;
    assign o_done   = done_r;

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//
// Self-checking bench for piso_serializer (WIDTH = 8). A queue-based
// reference model holds the bits of the frame in flight; every cycle the
// DUT outputs are compared against it. Directed scenarios also compare the
// captured serial stream and o_done pulse counts against constants.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

    localparam int   W    = 8;
    localparam logic IDLE = 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int   FL   = W + 1;
`else
    localparam int   FL   = W;
`endif

    logic         i_clk;
    logic         i_rst_n;
    logic [W-1:0] i_data;
    logic         i_valid;
    logic         o_ready;
    logic         i_shift;
    logic         o_sdata;
    logic         o_active;
    logic         o_done;

    piso_serializer #(.WIDTH(W), .IDLE_LEVEL(IDLE)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_data   (i_data),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_shift  (i_shift),
        .o_sdata  (o_sdata),
        .o_active (o_active),
        .o_done   (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    bit           fq[$];      // remaining bits of the frame on the wire
    bit           m_busy = 1'b0;
    bit           m_done = 1'b0;
    logic [W-1:0] tx_q[$];    // words the master still wants to send

    // Observed serial capture.
    logic [63:0]  cap;
    int           ncap;
    int           ndone;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame as an integer value, first bit in the most significant position.
    function automatic logic [63:0] frame_val(input logic [W-1:0] d);
        logic [63:0] v;
        v = 64'(d);
`ifdef PISO_SERIALIZER_PARITY_EN
        v = (v << 1) | 64'(^d);
`endif
        return v;
    endfunction

    task automatic clear_capture();
        cap   = 64'd0;
        ncap  = 0;
        ndone = 0;
    endtask

    // One clock cycle: drive, compare against model, advance model at edge.
    task automatic step(input logic rst_n, input logic shift);
        logic e_ready, e_active, e_sdata, acc;
        logic [W-1:0] d;
        @(negedge i_clk);
        i_rst_n = rst_n;
        i_shift = shift;
        i_valid = (tx_q.size() > 0);
        d       = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
        i_data  = d;
        #1;
        e_active = rst_n && m_busy;
        e_sdata  = e_active ? fq[0] : IDLE;
        e_ready  = rst_n && (!m_busy || ((fq.size() == 1) && shift));
        check_val("ready",  64'(o_ready),  64'(e_ready));
        check_val("active", 64'(o_active), 64'(e_active));
        check_val("sdata",  64'(o_sdata),  64'(e_sdata));
        check_val("done",   64'(o_done),   64'(m_done));
        if (o_done) ndone++;
        if (o_active && shift) begin
            cap = {cap[62:0], o_sdata};
            ncap++;
        end
        acc = i_valid && e_ready;
        @(posedge i_clk);
        if (!rst_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            fq.delete();
        end else begin
            m_done = 1'b0;
            if (m_busy && shift) begin
                void'(fq.pop_front());
                if (fq.size() == 0) begin
                    m_done = 1'b1;
                    m_busy = 1'b0;
                end
            end
            if (acc) begin
                for (int i = W - 1; i >= 0; i--) fq.push_back(d[i]);
`ifdef PISO_SERIALIZER_PARITY_EN
                fq.push_back(^d);
`endif
                m_busy = 1'b1;
                void'(tx_q.pop_front());
            end
        end
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_valid = 1'b1;
        i_data  = 8'hC3;
        i_shift = 1'b1;
        clear_capture();
        @(posedge i_clk);

        // Reset held with a pending word: nothing may be accepted.
        tx_q.push_back(8'hC3);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        tx_q.delete();
        step(1'b1, 1'b1);
        check_val("rst_noaccept_active", 64'(o_active), 64'd0);

        // Single word, continuous ticks.
        clear_capture();
        tx_q.push_back(8'hA5);
        for (int i = 0; i < FL + 4; i++) step(1'b1, 1'b1);
        check_val("a5_bits",  cap, frame_val(8'hA5));
        check_val("a5_nbits", 64'(ncap), 64'(FL));
        check_val("a5_done",  64'(ndone), 64'd1);

        // Sparse ticks: every 4th cycle.
        clear_capture();
        tx_q.push_back(8'h3C);
        for (int i = 0; i < 4 * FL + 8; i++) step(1'b1, (i % 4) == 3);
        check_val("3c_bits",  cap, frame_val(8'h3C));
        check_val("3c_nbits", 64'(ncap), 64'(FL));
        check_val("3c_done",  64'(ndone), 64'd1);

        // Back-to-back, gapless.
        clear_capture();
        tx_q.push_back(8'hFF);
        tx_q.push_back(8'h81);
        for (int i = 0; i < 2 * FL + 4; i++) step(1'b1, 1'b1);
        check_val("b2b_bits",  cap, (frame_val(8'hFF) << FL) | frame_val(8'h81));
        check_val("b2b_nbits", 64'(ncap), 64'(2 * FL));
        check_val("b2b_done",  64'(ndone), 64'd2);

        // Reset mid-frame after 3 bits, then a clean frame.
        clear_capture();
        tx_q.push_back(8'hF0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        tx_q.push_back(8'h99);
        step(1'b0, 1'b1);
        tx_q.delete();
        step(1'b1, 1'b0);
        check_val("midrst_done", 64'(ndone), 64'd0);
        clear_capture();
        tx_q.push_back(8'h55);
        for (int i = 0; i < FL + 4; i++) step(1'b1, 1'b1);
        check_val("55_bits", cap, frame_val(8'h55));
        check_val("55_done", 64'(ndone), 64'd1);

        // 0x07: parity bit is 1 when enabled.
        clear_capture();
        tx_q.push_back(8'h07);
        for (int i = 0; i < FL + 4; i++) step(1'b1, 1'b1);
        check_val("07_bits",  cap, frame_val(8'h07));
        check_val("07_nbits", 64'(ncap), 64'(FL));

        // Randomized traffic with varying tick density and rare resets.
        for (int blk = 0; blk < 8; blk++) begin
            int dens;
            dens = blk % 4;
            for (int i = 0; i < 150; i++) begin
                if ((tx_q.size() < 2) && ($urandom_range(0, 2) == 0))
                    tx_q.push_back(W'($urandom));
                step(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) <= dens));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
